// File: rtl/chr_fetch_arbiter_pkg.sv
// chr_arb_pkg: shared types for the CHR ROM fetch arbiter.
package chr_arb_pkg;
    localparam int CHR_ADDR_W = 13;
    typedef enum logic [1:0] {REQ_BG, REQ_SPR, REQ_CPU} requester_t;
    typedef struct packed {logic valid; requester_t who;} chr_tag_t;
    function automatic logic tag_hit(chr_tag_t t, requester_t w);
        return t.valid && t.who == w;
    endfunction
endpackage

// File: rtl/chr_fetch_arbiter_if.sv
// chr_fetch_arbiter_if: requester handshakes and ROM port wiring around the arbiter.
interface chr_fetch_arbiter_if #(parameter int ADDR_W = chr_arb_pkg::CHR_ADDR_W);
    logic              clk_en;
    logic              render;
    logic              bg_req, spr_req, cpu_req;
    logic [ADDR_W-1:0] bg_addr, spr_addr, cpu_addr;
    logic              bg_gnt, spr_gnt, cpu_gnt;
    logic              bg_rvalid, spr_rvalid, cpu_rvalid;
    logic [7:0]        bg_rdata, spr_rdata, cpu_rdata;
    logic [ADDR_W-1:0] rom_addr1, rom_addr2;
    logic [7:0]        rom_data1, rom_data2;
    modport master(
        output clk_en, render, bg_req, bg_addr, spr_req, spr_addr, cpu_req, cpu_addr,
        rom_data1, rom_data2,
        input bg_gnt, spr_gnt, cpu_gnt, bg_rvalid, spr_rvalid, cpu_rvalid,
        bg_rdata, spr_rdata, cpu_rdata, rom_addr1, rom_addr2
    );
    modport slave(
        input clk_en, render, bg_req, bg_addr, spr_req, spr_addr, cpu_req, cpu_addr,
        rom_data1, rom_data2,
        output bg_gnt, spr_gnt, cpu_gnt, bg_rvalid, spr_rvalid, cpu_rvalid,
        bg_rdata, spr_rdata, cpu_rdata, rom_addr1, rom_addr2
    );
endinterface

// File: rtl/chr_fetch_arbiter_pick.sv
// chr_arb_pick: picks the two highest-priority pending requesters for ROM ports A and B.
module chr_arb_pick
    import chr_arb_pkg::*;
(
    input  logic            [2:0] req,
    input  logic [2:0][1:0]       order,
    output chr_tag_t              port_a,
    output chr_tag_t              port_b
);
    always_comb begin
        port_a = '0;
        port_b = '0;
        for (int i = 0; i < 3; i++)
            if (req[order[i]]) begin
                if (!port_a.valid) port_a = {1'b1, requester_t'(order[i])};
                else if (!port_b.valid) port_b = {1'b1, requester_t'(order[i])};
            end
    end
endmodule

// File: rtl/chr_fetch_arbiter.sv
// chr_fetch_arbiter: shares the dual-port CHR ROM between BG, SPR and CPU with CPU anti-starvation.
module chr_fetch_arbiter
    import chr_arb_pkg::*;
#(
    parameter int ADDR_W    = CHR_ADDR_W,
    parameter int AGE_LIMIT = 8
) (
    input logic              clk,
    input logic              rst,
    chr_fetch_arbiter_if.slave bus
);
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);
    logic [AGE_W-1:0]        cpu_age;
    logic [2:0]              req;
    logic [2:0][1:0]         order;
    logic [2:0][ADDR_W-1:0]  addr;
    logic [2:0][7:0]         rdata;
    logic [ADDR_W-1:0]       addr_a_q, addr_b_q;
    chr_tag_t                tag_a, tag_b, s1_a, s1_b, s2_a, s2_b;
    assign req   = {bus.cpu_req, bus.spr_req, bus.bg_req} & {3{bus.clk_en && !rst}};
    assign addr  = {bus.cpu_addr, bus.spr_addr, bus.bg_addr};
    // order[0] is the highest priority; an aged CPU request jumps the queue
    assign order = (!bus.render || cpu_age == AGE_W'(AGE_LIMIT)) ? {REQ_SPR, REQ_BG, REQ_CPU}
                                                                 : {REQ_CPU, REQ_SPR, REQ_BG};
    chr_arb_pick u_pick (
        .req    (req),
        .order  (order),
        .port_a (tag_a),
        .port_b (tag_b)
    );
    assign bus.bg_gnt     = tag_hit(tag_a, REQ_BG)  || tag_hit(tag_b, REQ_BG);
    assign bus.spr_gnt    = tag_hit(tag_a, REQ_SPR) || tag_hit(tag_b, REQ_SPR);
    assign bus.cpu_gnt    = tag_hit(tag_a, REQ_CPU) || tag_hit(tag_b, REQ_CPU);
    assign bus.rom_addr1  = tag_a.valid ? addr[tag_a.who] : addr_a_q;
    assign bus.rom_addr2  = tag_b.valid ? addr[tag_b.who] : addr_b_q;
    assign bus.bg_rvalid  = tag_hit(s2_a, REQ_BG)  || tag_hit(s2_b, REQ_BG);
    assign bus.spr_rvalid = tag_hit(s2_a, REQ_SPR) || tag_hit(s2_b, REQ_SPR);
    assign bus.cpu_rvalid = tag_hit(s2_a, REQ_CPU) || tag_hit(s2_b, REQ_CPU);
    assign bus.bg_rdata   = rdata[REQ_BG];
    assign bus.spr_rdata  = rdata[REQ_SPR];
    assign bus.cpu_rdata  = rdata[REQ_CPU];
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_a_q <= '0;
            addr_b_q <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_a     <= '0;
            s2_b     <= '0;
            rdata    <= '0;
            cpu_age  <= '0;
        end else begin
            addr_a_q <= bus.rom_addr1;
            addr_b_q <= bus.rom_addr2;
            s1_a     <= tag_a;
            s1_b     <= tag_b;
            s2_a     <= s1_a;
            s2_b     <= s1_b;
            // ROM data for a stage-1 tag is on the data ports now; capture into its owner
            if (s1_a.valid) rdata[s1_a.who] <= bus.rom_data1;
            if (s1_b.valid) rdata[s1_b.who] <= bus.rom_data2;
            cpu_age  <= (!bus.cpu_req || bus.cpu_gnt) ? '0
                      : (bus.clk_en && cpu_age != AGE_W'(AGE_LIMIT)) ? cpu_age + 1'b1 : cpu_age;
        end
    end
endmodule

// File: tb/tb_chr_fetch_arbiter.sv
// tb_chr_fetch_arbiter: directed + random stimulus against a queue-based reference model.
module tb_chr_fetch_arbiter;
    localparam int AGE_LIMIT = 8;
    typedef struct {int due; int who; logic [7:0] data;} deliv_t;
    logic clk = 0, rst = 1;
    chr_fetch_arbiter_if bus();
    chr_fetch_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [7:0] rom_val(logic [12:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction
    always @(posedge clk) begin
        bus.rom_data1 <= rom_val(bus.rom_addr1);
        bus.rom_data2 <= rom_val(bus.rom_addr2);
    end
    int checks = 0, failures = 0, cyc = 0, age_m = 0;
    deliv_t pend[$];
    logic [7:0] rd_m[3];
    logic [12:0] hold1, hold2;
    bit obs_gnt[3], obs_rv[3];
    logic [7:0] obs_rd[3];
    logic [12:0] obs_a1, obs_a2;
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    task automatic model_reset();
        pend.delete();
        rd_m = '{8'h00, 8'h00, 8'h00};
        age_m = 0;
        hold1 = '0;
        hold2 = '0;
    endtask
    // One clock: compare DUT against the model mid-cycle, then advance the model past the posedge
    task automatic step();
        bit r[3], eg[3], ev[3], ok;
        logic [12:0] a[3];
        logic [12:0] ea1, ea2;
        int ord[3];
        int win[$];
        #1;
        r   = '{bus.bg_req, bus.spr_req, bus.cpu_req};
        a   = '{bus.bg_addr, bus.spr_addr, bus.cpu_addr};
        ok  = bus.clk_en && !rst;
        if (!bus.render || age_m == AGE_LIMIT) ord = '{2, 0, 1};
        else ord = '{0, 1, 2};
        foreach (ord[i]) if (ok && r[ord[i]]) win.push_back(ord[i]);
        eg = '{0, 0, 0};
        for (int k = 0; k < win.size() && k < 2; k++) eg[win[k]] = 1;
        ea1 = win.size() > 0 ? a[win[0]] : hold1;
        ea2 = win.size() > 1 ? a[win[1]] : hold2;
        ev = '{0, 0, 0};
        for (int i = pend.size() - 1; i >= 0; i--)
            if (pend[i].due == cyc) begin
                ev[pend[i].who] = 1;
                rd_m[pend[i].who] = pend[i].data;
                pend.delete(i);
            end
        obs_gnt = '{bus.bg_gnt, bus.spr_gnt, bus.cpu_gnt};
        obs_rv  = '{bus.bg_rvalid, bus.spr_rvalid, bus.cpu_rvalid};
        obs_rd  = '{bus.bg_rdata, bus.spr_rdata, bus.cpu_rdata};
        obs_a1  = bus.rom_addr1;
        obs_a2  = bus.rom_addr2;
        for (int w = 0; w < 3; w++) begin
            check($sformatf("gnt%0d", w), 32'(obs_gnt[w]), 32'(eg[w]));
            check($sformatf("rvalid%0d", w), 32'(obs_rv[w]), 32'(ev[w]));
            check($sformatf("rdata%0d", w), 32'(obs_rd[w]), 32'(rd_m[w]));
        end
        check("rom_addr1", 32'(obs_a1), 32'(ea1));
        check("rom_addr2", 32'(obs_a2), 32'(ea2));
        for (int k = 0; k < win.size() && k < 2; k++)
            pend.push_back('{due: cyc + 2, who: win[k], data: rom_val(a[win[k]])});
        hold1 = ea1;
        hold2 = ea2;
        if (!r[2]) age_m = 0;
        else if (bus.clk_en) age_m = eg[2] ? 0 : (age_m < AGE_LIMIT ? age_m + 1 : age_m);
        if (rst) model_reset();
        @(negedge clk);
        cyc++;
    endtask
    task automatic tick(bit en);
        bus.clk_en = en;
        step();
    endtask
    task automatic set_req(bit b, bit s, bit c);
        bus.bg_req = b;
        bus.spr_req = s;
        bus.cpu_req = c;
    endtask
    bit rq[3];
    logic [12:0] ad[3];
    int gnt_tick;
    logic [12:0] gnt_a1;
    initial begin
        bus.clk_en = 0; bus.render = 1;
        set_req(0, 0, 0);
        bus.bg_addr = '0; bus.spr_addr = '0; bus.cpu_addr = '0;
        repeat (3) @(negedge clk);
        model_reset();
        rst = 0;
        tick(1);
        // BG alone
        bus.bg_req = 1; bus.bg_addr = 13'h0010;
        tick(1);
        check("t1_gnt", 32'(obs_gnt[0]), 1);
        check("t1_addr1", 32'(obs_a1), 32'h0010);
        bus.bg_req = 0;
        tick(0); tick(0);
        check("t1_rvalid", 32'(obs_rv[0]), 1);
        check("t1_rdata", 32'(obs_rd[0]), 32'hB5);
        tick(0);
        // render=1 all three, then CPU alone
        bus.bg_addr = 13'h0100; bus.spr_addr = 13'h0200; bus.cpu_addr = 13'h0300;
        set_req(1, 1, 1);
        tick(1);
        check("t2_cpu_gnt", 32'(obs_gnt[2]), 0);
        check("t2_addr2", 32'(obs_a2), 32'h0200);
        set_req(0, 0, 1);
        tick(0); tick(0); tick(0); tick(1);
        check("t2_cpu_port_a", 32'(obs_a1), 32'h0300);
        // render=0: CPU first
        bus.render = 0;
        bus.bg_addr = 13'h0020; bus.spr_addr = 13'h0040; bus.cpu_addr = 13'h1FFF;
        set_req(1, 1, 1);
        tick(1);
        check("t3_addr1", 32'(obs_a1), 32'h1FFF);
        check("t3_addr2", 32'(obs_a2), 32'h0020);
        set_req(0, 0, 0);
        tick(0); tick(0);
        check("t3_cpu_rdata", 32'(obs_rd[2]), 32'h5A);
        tick(0);
        // CPU aging under constant BG+SPR load
        bus.render = 1;
        bus.cpu_addr = 13'h0ABC;
        set_req(1, 1, 1);
        gnt_tick = 0; gnt_a1 = '0;
        for (int t = 1; t <= 12; t++) begin
            tick(1);
            if (obs_gnt[2] && gnt_tick == 0) begin
                gnt_tick = t;
                gnt_a1 = obs_a1;
                bus.cpu_req = 0;
            end
            tick(0); tick(0); tick(0);
        end
        check("t4_gnt_tick", 32'(gnt_tick), 9);
        check("t4_port_a", 32'(gnt_a1), 32'h0ABC);
        set_req(0, 0, 0);
        tick(0); tick(0);
        // reset right after a grant
        bus.bg_req = 1; bus.bg_addr = 13'h0055;
        tick(1);
        bus.bg_req = 0; rst = 1;
        tick(0);
        rst = 0;
        tick(0);
        check("t5_no_rvalid", 32'(obs_rv[0]), 0);
        check("t5_rdata_clr", 32'(obs_rd[2]), 0);
        check("t5_addr1_clr", 32'(obs_a1), 0);
        bus.bg_req = 1; bus.bg_addr = 13'h0077;
        tick(1);
        bus.bg_req = 0;
        tick(0); tick(0);
        check("t5_post_rdata", 32'(obs_rd[0]), 32'hD2);
        // request held while clk_en is low
        bus.bg_req = 1; bus.bg_addr = 13'h00AA;
        for (int i = 0; i < 3; i++) begin
            tick(0);
            check("t6_no_gnt", 32'(obs_gnt[0]), 0);
            check("t6_addr_hold", 32'(obs_a1), 32'h0077);
        end
        tick(1);
        check("t6_gnt", 32'(obs_addr_gnt_bg()), 32'h00AA);
        bus.bg_req = 0;
        tick(0); tick(0); tick(0);
        // random traffic
        rq = '{0, 0, 0};
        ad = '{13'h0, 13'h0, 13'h0};
        for (int c = 0; c < 4000; c++) begin
            for (int w = 0; w < 3; w++)
                if (rq[w] && !obs_gnt[w]) rq[w] = $urandom_range(0, 15) != 0;
                else begin
                    rq[w] = $urandom_range(0, 2) == 0;
                    ad[w] = $urandom_range(0, 3) == 0 ? 13'h0010 : 13'($urandom);
                end
            set_req(rq[0], rq[1], rq[2]);
            bus.bg_addr = ad[0]; bus.spr_addr = ad[1]; bus.cpu_addr = ad[2];
            if ($urandom_range(0, 63) == 0) bus.render = ~bus.render;
            rst = $urandom_range(0, 299) == 0;
            tick(c % 4 == 0);
            if (rst) rq = '{0, 0, 0};
        end
        rst = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    function automatic logic [12:0] obs_addr_gnt_bg();
        return obs_gnt[0] ? obs_a1 : 13'h1FFF;
    endfunction
endmodule
